// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared types and quadrature step table for the encoder front end
// Contents: error counter width, decoder state encoding, step classification and lookup.
package encoder_pkg;

   localparam int ERR_W = 8;

   // Low two bits of every settled state equal the filtered {A,B} it represents,
   // so the decoder can feed state[1:0] straight into the step table.
   typedef enum logic [2:0] {
      ST_S00  = 3'b000,
      ST_S01  = 3'b001,
      ST_S10  = 3'b010,
      ST_S11  = 3'b011,
      ST_INIT = 3'b100
   } dec_state_t;

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_UP   = 2'd1,
      STEP_DN   = 2'd2,
      STEP_ILL  = 2'd3
   } step_t;

   // {prev,cur} -> step kind. Forward order is 00 -> 01 -> 11 -> 10 -> 00.
   function automatic step_t step_lookup(input logic [1:0] prev, input logic [1:0] cur);
      step_t kind;
      case ({prev, cur})
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: kind = STEP_UP;
         4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: kind = STEP_DN;
         4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: kind = STEP_ILL;
         default:                                kind = STEP_NONE;
      endcase
      return kind;
   endfunction

endpackage

// File: rtl/enc_glitch_filter.sv
// rtl/enc_glitch_filter.sv - two-flop synchroniser plus run-length glitch filter for one pin
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   raw         encoder pin, asynchronous to clk
//   level       filtered level, changes only after FILT_LEN equal synced samples
//   primed      set once the first run of FILT_LEN equal samples has been seen
module enc_glitch_filter #(
   parameter int FILT_LEN = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic primed
);

   localparam int               RUN_W   = $clog2(FILT_LEN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILT_LEN);
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

   logic             sync1;
   logic             sync2;
   logic             last;
   logic [RUN_W-1:0] run;
   logic [RUN_W-1:0] run_next;

   // run = length of the current streak of equal synced samples, saturating at FILT_LEN.
   // A sample differing from its predecessor starts a new streak of length one, so a
   // pulse shorter than FILT_LEN never reaches RUN_MAX and is discarded.
   always_comb begin
      run_next = run;
      if (sync2 != last) begin
         run_next = RUN_ONE;
      end else if (run != RUN_MAX) begin
         run_next = run + RUN_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         last   <= 1'b0;
         run    <= '0;
         level  <= 1'b0;
         primed <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         last  <= sync2;
         run   <= run_next;
         // The streak is complete on the very cycle its FILT_LEN-th sample arrives.
         if (run_next == RUN_MAX) begin
            level  <= sync2;
            primed <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/encoder_quad_decoder.sv
// rtl/encoder_quad_decoder.sv - quadrature decoder, position counter, windowed velocity, error count
// Ports:
//   s_axi_aclk, s_axi_aresetn  clock, asynchronous active-low reset
//   enc_a, enc_b               raw encoder pins
//   ctrl_enable                count steps and run the velocity window
//   ctrl_clear                 clear position, velocity, accumulator, window and errors
//   ctrl_dir_invert            negate step direction
//   position                   wrapping two's complement step count
//   velocity, vel_valid        signed steps in the last complete window, update pulse
//   step_pulse, step_dir       counted-step pulse and its direction (1 = up)
//   err_count, err_sticky      saturating illegal-transition count and sticky flag
module encoder_quad_decoder
   import encoder_pkg::*;
#(
   parameter int FILT_LEN = 4,
   parameter int CNT_W    = 32,
   parameter int VEL_W    = 16,
   parameter int VEL_WIN  = 1000000
) (
   input  logic                    s_axi_aclk,
   input  logic                    s_axi_aresetn,
   input  logic                    enc_a,
   input  logic                    enc_b,
   input  logic                    ctrl_enable,
   input  logic                    ctrl_clear,
   input  logic                    ctrl_dir_invert,
   output logic [CNT_W-1:0]        position,
   output logic signed [VEL_W-1:0] velocity,
   output logic                    vel_valid,
   output logic                    step_pulse,
   output logic                    step_dir,
   output logic [ERR_W-1:0]        err_count,
   output logic                    err_sticky
);

   localparam int                 WIN_W    = $clog2(VEL_WIN);
   localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(VEL_WIN - 1);
   localparam logic signed [VEL_W:0] SUM_MAX = (VEL_W + 1)'(2 ** (VEL_W - 1) - 1);
   localparam logic signed [VEL_W:0] SUM_MIN = -SUM_MAX;
   localparam logic signed [VEL_W:0] SV_ONE  = (VEL_W + 1)'(1);

   logic filt_a, filt_b, primed_a, primed_b;

   enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
      .clk    (s_axi_aclk),
      .rst_n  (s_axi_aresetn),
      .raw    (enc_a),
      .level  (filt_a),
      .primed (primed_a)
   );

   enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
      .clk    (s_axi_aclk),
      .rst_n  (s_axi_aresetn),
      .raw    (enc_b),
      .level  (filt_b),
      .primed (primed_b)
   );

   // ---------------- decoder FSM ----------------
   dec_state_t state, state_next;
   step_t      kind;
   logic [1:0] cur_ab;

   assign cur_ab = {filt_a, filt_b};

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state <= ST_INIT;
      end else begin
         state <= state_next;
      end
   end

   // The FSM follows the filtered pins regardless of ctrl_enable so that re-enabling
   // never produces a spurious step from a stale state.
   always_comb begin
      state_next = state;
      kind       = STEP_NONE;
      if (state == ST_INIT) begin
         if (primed_a && primed_b) begin
            state_next = dec_state_t'({1'b0, cur_ab});
         end
      end else begin
         kind       = step_lookup(state[1:0], cur_ab);
         state_next = dec_state_t'({1'b0, cur_ab});
      end
   end

   // ---------------- step qualification ----------------
   logic step_valid;
   logic step_up;
   logic illegal;

   assign step_valid = ctrl_enable && ((kind == STEP_UP) || (kind == STEP_DN));
   assign step_up    = (kind == STEP_UP) ^ ctrl_dir_invert;
   assign illegal    = (kind == STEP_ILL);

   // ---------------- velocity accumulator ----------------
   logic [WIN_W-1:0]        win;
   logic signed [VEL_W-1:0] acc;
   logic signed [VEL_W-1:0] acc_sat;
   logic signed [VEL_W:0]   step_val;
   logic signed [VEL_W:0]   acc_sum;

   always_comb begin
      step_val = '0;
      if (step_valid) begin
         step_val = step_up ? SV_ONE : -SV_ONE;
      end
      acc_sum = {acc[VEL_W-1], acc} + step_val;
      if (acc_sum > SUM_MAX) begin
         acc_sat = SUM_MAX[VEL_W-1:0];
      end else if (acc_sum < SUM_MIN) begin
         acc_sat = SUM_MIN[VEL_W-1:0];
      end else begin
         acc_sat = acc_sum[VEL_W-1:0];
      end
   end

   // ---------------- registered outputs ----------------
   // ctrl_clear takes priority over everything on its cycle: the step, the window end
   // and any illegal transition occurring on that cycle are all discarded.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         position   <= '0;
         velocity   <= '0;
         vel_valid  <= 1'b0;
         step_pulse <= 1'b0;
         step_dir   <= 1'b0;
         err_count  <= '0;
         err_sticky <= 1'b0;
         win        <= '0;
         acc        <= '0;
      end else begin
         step_pulse <= 1'b0;
         vel_valid  <= 1'b0;
         if (ctrl_clear) begin
            position   <= '0;
            velocity   <= '0;
            acc        <= '0;
            win        <= '0;
            err_count  <= '0;
            err_sticky <= 1'b0;
         end else begin
            if (step_valid) begin
               position   <= step_up ? position + CNT_W'(1) : position - CNT_W'(1);
               step_dir   <= step_up;
               step_pulse <= 1'b1;
            end
            if (illegal) begin
               if (err_count != '1) begin
                  err_count <= err_count + ERR_W'(1);
               end
               err_sticky <= 1'b1;
            end
            if (ctrl_enable) begin
               if (win == WIN_LAST) begin
                  win       <= '0;
                  velocity  <= acc_sat;
                  acc       <= '0;
                  vel_valid <= 1'b1;
               end else begin
                  win <= win + WIN_W'(1);
                  acc <= acc_sat;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_encoder_quad_decoder.sv
// tb/tb_encoder_quad_decoder.sv - scoreboard bench for encoder_quad_decoder
module tb_encoder_quad_decoder;
   import encoder_pkg::*;

   localparam int FL   = 4;
   localparam int CW   = 8;
   localparam int VW   = 16;
   localparam int VWIN = 100;
   localparam int LAT  = FL + 3;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 enc_a, enc_b;
   logic                 ctrl_enable, ctrl_clear, ctrl_dir_invert;
   logic [CW-1:0]        position;
   logic signed [VW-1:0] velocity;
   logic                 vel_valid, step_pulse, step_dir;
   logic [7:0]           err_count;
   logic                 err_sticky;

   encoder_quad_decoder #(.FILT_LEN(FL), .CNT_W(CW), .VEL_W(VW), .VEL_WIN(VWIN)) dut (
      .s_axi_aclk      (clk),
      .s_axi_aresetn   (rst_n),
      .enc_a           (enc_a),
      .enc_b           (enc_b),
      .ctrl_enable     (ctrl_enable),
      .ctrl_clear      (ctrl_clear),
      .ctrl_dir_invert (ctrl_dir_invert),
      .position        (position),
      .velocity        (velocity),
      .vel_valid       (vel_valid),
      .step_pulse      (step_pulse),
      .step_dir        (step_dir),
      .err_count       (err_count),
      .err_sticky      (err_sticky)
   );

   initial begin
      forever #5 clk = ~clk;
   end

   typedef struct { int at; logic dir; logic [CW-1:0] pos; } step_rec_t;
   typedef struct { int at; logic [7:0] cnt; } err_rec_t;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   step_rec_t  sq[$];
   err_rec_t   eq[$];
   int         step_at[int];
   logic [1:0] lvl;
   logic [CW-1:0] m_pos;
   int         m_err;
   bit         en, inv;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Position of a Gray-coded {A,B} pair along the forward cycle 00,01,11,10.
   function automatic int qidx(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] qab(input int i);
      logic [1:0] v;
      v = 2'(i % 4);
      return {v[1], v[1] ^ v[0]};
   endfunction

   // Drive a new pin pair for 'hold' cycles and record the expected consequences.
   // A level held shorter than FL is a glitch and must return to lvl afterwards.
   // drop=1 issues ctrl_clear on exactly the cycle the resulting step would land.
   task automatic move(input logic [1:0] ab, input int hold, input bit drop);
      int at, d;
      bit up;
      at = cyc + LAT;
      if (hold >= FL && ab != lvl) begin
         d = (qidx(ab) - qidx(lvl) + 4) % 4;
         if (d == 2) begin
            if (m_err < 255) begin
               m_err++;
               eq.push_back('{at, 8'(m_err)});
            end
         end else if (en) begin
            up = (d == 1) ^ inv;
            if (drop) begin
               m_pos = '0;
               m_err = 0;
            end else begin
               m_pos = up ? m_pos + CW'(1) : m_pos - CW'(1);
               sq.push_back('{at, up, m_pos});
               step_at[at] = up ? 1 : -1;
            end
         end
         lvl = ab;
      end
      {enc_a, enc_b} = ab;
      if (drop) begin
         repeat (LAT - 1) @(negedge clk);
         ctrl_clear = 1'b1;
         @(negedge clk);
         ctrl_clear = 1'b0;
         repeat (hold - LAT) @(negedge clk);
      end else begin
         repeat (hold) @(negedge clk);
      end
   endtask

   task automatic settle();
      repeat (LAT + 3) @(negedge clk);
   endtask

   task automatic do_clear(output int at);
      at = cyc;
      ctrl_clear = 1'b1;
      @(negedge clk);
      ctrl_clear = 1'b0;
      m_pos = '0;
      m_err = 0;
   endtask

   task automatic wait_vel(output longint v, output int at);
      int n = 0;
      while (vel_valid !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("vel_timeout", longint'(n < 300), 1);
      v  = longint'(velocity);
      at = cyc;
      @(negedge clk);
   endtask

   // Monitor: sampled 1 time unit after each rising edge.
   initial begin
      int   wcnt = 0;
      int   wsum = 0;
      int   expvel;
      bit   expv;
      logic [7:0] prev_err = '0;
      step_rec_t s;
      err_rec_t  e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (sq.size() > 0 && sq[0].at == cyc) begin
            s = sq.pop_front();
            chk("step_pulse", step_pulse, 1);
            chk("step_dir", step_dir, s.dir);
            chk("step_pos", position, s.pos);
         end else if (step_pulse) begin
            chk("step_unexpected", step_pulse, 0);
         end
         if (eq.size() > 0 && eq[0].at == cyc) begin
            e = eq.pop_front();
            chk("err_count", err_count, e.cnt);
            chk("err_sticky", err_sticky, 1);
         end else if (err_count != prev_err && !ctrl_clear) begin
            chk("err_unexpected", err_count, prev_err);
         end
         prev_err = err_count;
         if (ctrl_clear) begin
            chk("clr_pos", position, 0);
            chk("clr_err", err_count, 0);
            chk("clr_sticky", err_sticky, 0);
            chk("clr_vel", velocity, 0);
         end
         // Velocity window: VWIN enabled cycles since the last clear or window end.
         expv = 1'b0;
         if (ctrl_clear) begin
            wcnt = 0;
            wsum = 0;
         end else if (ctrl_enable) begin
            if (step_at.exists(cyc)) wsum += step_at[cyc];
            wcnt++;
            if (wcnt == VWIN) begin
               expv   = 1'b1;
               expvel = wsum;
               wcnt   = 0;
               wsum   = 0;
            end
         end
         if (expv || vel_valid) begin
            chk("vel_valid", vel_valid, expv);
            if (expv) chk("velocity", velocity, expvel);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int     c, at;
      longint v;
      rst_n = 1'b0;
      {enc_a, enc_b} = 2'b11;
      ctrl_enable = 1'b0;
      ctrl_clear = 1'b0;
      ctrl_dir_invert = 1'b0;
      en = 1'b0;
      inv = 1'b0;
      m_pos = '0;
      m_err = 0;
      lvl = 2'b11;
      repeat (3) @(negedge clk);
      chk("rst_pos", position, 0);
      chk("rst_vel", velocity, 0);
      chk("rst_step", step_pulse, 0);
      chk("rst_err", err_count, 0);
      chk("rst_sticky", err_sticky, 0);
      chk("rst_state", dut.state, ST_INIT);

      // 1: reset released with A=B=1
      rst_n = 1'b1;
      repeat (LAT - 1) @(negedge clk);
      chk("init_hold", dut.state, ST_INIT);
      @(negedge clk);
      chk("init_s11", dut.state, ST_S11);
      chk("init_pos", position, 0);
      chk("init_sticky", err_sticky, 0);

      // 2: four forward cycles, then three reverse steps
      ctrl_enable = 1'b1;
      en = 1'b1;
      for (int i = 0; i < 16; i++) move(qab(qidx(lvl) + 1), 10, 1'b0);
      settle();
      chk("fwd16_pos", position, 16);
      chk("fwd16_dir", step_dir, 1);
      for (int i = 0; i < 3; i++) move(qab(qidx(lvl) + 3), 10, 1'b0);
      settle();
      chk("rev3_pos", position, 13);

      // 3: glitches on channel A
      move(lvl ^ 2'b10, FL - 1, 1'b0);
      move(lvl, 10, 1'b0);
      settle();
      chk("glitch_short_pos", position, 13);
      move(lvl ^ 2'b10, FL, 1'b0);
      settle();
      chk("glitch_len_pos", position, m_pos);

      // 4: illegal jumps and saturation
      c = int'(position);
      move(lvl ^ 2'b11, 10, 1'b0);
      settle();
      chk("ill1_cnt", err_count, 1);
      chk("ill1_sticky", err_sticky, 1);
      chk("ill1_pos", position, c);
      for (int i = 0; i < 299; i++) move(lvl ^ 2'b11, FL, 1'b0);
      settle();
      chk("ill_sat", err_count, 255);

      // 5: wrap below zero, clear coinciding with a step
      do_clear(at);
      settle();
      move(qab(qidx(lvl) + 3), 10, 1'b0);
      settle();
      chk("wrap_pos", position, 255);
      move(qab(qidx(lvl) + 1), 10, 1'b1);
      settle();
      chk("clrstep_pos", position, 0);
      chk("clrstep_err", err_count, 0);

      // 6: velocity windows
      do_clear(c);
      for (int i = 0; i < 10; i++) move(qab(qidx(lvl) + 1), 5, 1'b0);
      wait_vel(v, at);
      chk("win_vel10", v, 10);
      chk("win_at", at, c + VWIN + 1);
      wait_vel(v, at);
      chk("win_idle", v, 0);
      chk("win_idle_at", at, c + 2 * VWIN + 1);
      settle();
      ctrl_dir_invert = 1'b1;
      inv = 1'b1;
      do_clear(c);
      for (int i = 0; i < 10; i++) move(qab(qidx(lvl) + 1), 5, 1'b0);
      wait_vel(v, at);
      chk("win_inv", v, -10);
      chk("inv_pos", position, 246);
      ctrl_dir_invert = 1'b0;
      inv = 1'b0;
      settle();
      ctrl_enable = 1'b0;
      en = 1'b0;
      do_clear(c);
      for (int i = 0; i < 10; i++) move(qab(qidx(lvl) + 1), 6, 1'b0);
      repeat (150) @(negedge clk);
      chk("dis_win_held", dut.win, 0);
      chk("dis_pos", position, 0);
      ctrl_enable = 1'b1;
      en = 1'b1;

      // Randomised walk with glitches and illegal jumps, both directions of invert
      for (int ph = 0; ph < 2; ph++) begin
         settle();
         inv = bit'(ph);
         ctrl_dir_invert = inv;
         for (int i = 0; i < 50; i++) begin
            int r;
            logic [1:0] keep;
            r = $urandom_range(0, 9);
            if (r < 4) begin
               move(qab(qidx(lvl) + 1), $urandom_range(FL, 12), 1'b0);
            end else if (r < 8) begin
               move(qab(qidx(lvl) + 3), $urandom_range(FL, 12), 1'b0);
            end else if (r == 8) begin
               keep = lvl;
               move(lvl ^ (($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01), $urandom_range(1, FL - 1), 1'b0);
               move(keep, $urandom_range(FL, 12), 1'b0);
            end else begin
               move(lvl ^ 2'b11, $urandom_range(FL, 12), 1'b0);
            end
         end
      end
      settle();
      chk("end_step_q", sq.size(), 0);
      chk("end_err_q", eq.size(), 0);
      chk("end_pos", position, m_pos);
      chk("end_err", err_count, m_err);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
